instr_stream_sequencer: RTL and testbench

//  Synthesizable, parametrised program sequencer that streams instruction words into the processor

---
 rtl/instr_stream_sequencer_pkg.sv | 6 +
 rtl/instr_stream_sequencer_if.sv | 12 +
 rtl/instr_stream_sequencer_buf.sv | 25 ++
 rtl/instr_stream_sequencer.sv | 99 +++++++++
 tb/tb_instr_stream_sequencer.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/instr_stream_sequencer_pkg.sv
// instr_seq_pkg: sequencer state encoding and default program constants
package instr_seq_pkg;
    typedef enum logic [2:0] {IDLE, FETCH, ISSUE, HOLD, WAIT_STEP, DONE} seq_state_t;
    localparam int DEF_HOLD_CYCLES = 6;
    localparam logic [15:0] DEF_EOF_WORD = 16'h0000;
endpackage

// File: rtl/instr_stream_sequencer_if.sv
// instr_stream_sequencer_if: instruction valid/ready stream from sequencer to core
interface instr_stream_sequencer_if #(
    parameter int INSTR_W = 16,
    parameter int ADDR_W = 5
);
    logic [INSTR_W-1:0] instr_out;
    logic               instr_valid;
    logic               instr_ready;
    logic [ADDR_W-1:0]  pc_out;
    modport master (output instr_out, instr_valid, pc_out, input instr_ready);
    modport slave (input instr_out, instr_valid, pc_out, output instr_ready);
endinterface

// File: rtl/instr_stream_sequencer_buf.sv
// instr_buf_sp: program buffer with one write port and one enabled, registered read port
module instr_buf_sp #(
    parameter int W = 16,
    parameter int D = 32,
    parameter int AW = $clog2(D)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);
    logic [W-1:0] mem [D];
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end
    // the read register doubles as the issued word, so it only moves on a fetch
    always_ff @(posedge clk) begin
        if (rst) rdata <= '0;
        else if (re) rdata <= mem[raddr];
    end
endmodule

// File: rtl/instr_stream_sequencer.sv
// instr_stream_sequencer: streams a loaded program into the core one word per handshake
module instr_stream_sequencer
    import instr_seq_pkg::*;
#(
    parameter int                 INSTR_W     = 16,
    parameter int                 DEPTH       = 32,
    parameter int                 ADDR_W      = $clog2(DEPTH),
    parameter int                 HOLD_CYCLES = DEF_HOLD_CYCLES,
    parameter logic [INSTR_W-1:0] EOF_WORD    = INSTR_W'(DEF_EOF_WORD),
    parameter int                 CNT_W       = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load_en,
    input  logic [ADDR_W-1:0]    load_addr,
    input  logic [INSTR_W-1:0]   load_data,
    input  logic                 start,
    input  logic                 abort,
    input  logic                 loop_en,
    input  logic                 step_mode,
    input  logic                 step,
    instr_stream_sequencer_if.master s,
    output logic                 busy,
    output logic                 done,
    output logic                 overrun,
    output logic                 load_err,
    output logic [CNT_W-1:0]     issue_count
);
    localparam int HC_W = HOLD_CYCLES > 1 ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [HC_W-1:0] HOLD_INIT = HC_W'(HOLD_CYCLES > 0 ? HOLD_CYCLES - 1 : 0);
    seq_state_t state, ns;
    logic [ADDR_W-1:0] pc, adv_pc;
    logic [HC_W-1:0] hold_cnt;
    logic [INSTR_W-1:0] word;
    logic valid_q, eof, last, ends, finish, xfer, hold_end, go_start, go_adv;
    instr_buf_sp #(.W(INSTR_W), .D(DEPTH), .AW(ADDR_W)) u_buf (
        .clk   (clk),
        .rst   (rst),
        .we    (load_en && !busy),
        .waddr (load_addr),
        .wdata (load_data),
        .re    (state == FETCH && !abort),
        .raddr (pc),
        .rdata (word)
    );
    assign s.instr_out = word;
    assign s.instr_valid = valid_q;
    assign s.pc_out = pc;
    // hold_end also fires on the transfer itself when there is no hold window
    always_comb begin
        eof = word == EOF_WORD;
        last = pc == ADDR_W'(DEPTH - 1);
        ends = eof || last;
        finish = ends && !loop_en;
        xfer = state == ISSUE && s.instr_ready;
        hold_end = (state == HOLD && hold_cnt == '0) || (xfer && HOLD_CYCLES == 0);
        go_start = start && (state == IDLE || state == DONE);
        go_adv = (hold_end && !step_mode) || (state == WAIT_STEP && step);
        adv_pc = finish ? pc : ends ? '0 : pc + ADDR_W'(1);
        ns = abort ? IDLE
           : go_start ? FETCH
           : go_adv ? (finish ? DONE : FETCH)
           : hold_end ? WAIT_STEP
           : xfer ? HOLD
           : state == FETCH ? ISSUE
           : state;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            pc <= '0;
            hold_cnt <= '0;
            valid_q <= 1'b0;
            busy <= 1'b0;
            done <= 1'b0;
            overrun <= 1'b0;
            load_err <= 1'b0;
            issue_count <= '0;
        end else begin
            state <= ns;
            valid_q <= ns == ISSUE;
            busy <= ns != IDLE && ns != DONE;
            load_err <= load_err || (load_en && busy);
            hold_cnt <= xfer ? HOLD_INIT : (state == HOLD && hold_cnt != '0) ? hold_cnt - HC_W'(1) : hold_cnt;
            if (!abort && go_start) begin
                pc <= '0;
                done <= 1'b0;
                overrun <= 1'b0;
                issue_count <= '0;
            end
            if (!abort && go_adv) begin
                pc <= adv_pc;
                done <= finish;
                overrun <= finish && !eof;
            end
            if (!abort && xfer) issue_count <= &issue_count ? issue_count : issue_count + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_instr_stream_sequencer.sv
// tb_instr_stream_sequencer: scoreboard bench for the sequencer at DEPTH=4, HOLD_CYCLES=6
module tb_instr_stream_sequencer;
    localparam int IW = 16, DP = 4, AW = 2;
    typedef struct {int pc; int w;} exp_t;
    logic clk = 0, rst = 1, load_en = 0, start = 0, abort = 0, loop_en = 0, step_mode = 0, step = 0;
    logic [AW-1:0] load_addr = '0;
    logic [IW-1:0] load_data = '0;
    logic busy, done, overrun, load_err;
    logic [15:0] issue_count;
    int n_chk = 0, n_err = 0, cyc = 0, t0 = 0;
    exp_t q[$];
    int xc[$];
    instr_stream_sequencer_if #(.INSTR_W(IW), .ADDR_W(AW)) sif();
    instr_stream_sequencer #(.INSTR_W(IW), .DEPTH(DP), .HOLD_CYCLES(6)) dut (
        .clk(clk), .rst(rst), .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
        .start(start), .abort(abort), .loop_en(loop_en), .step_mode(step_mode), .step(step),
        .s(sif), .busy(busy), .done(done), .overrun(overrun), .load_err(load_err),
        .issue_count(issue_count)
    );
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    task automatic check(input string tag, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask
    // each cycle a word is offered it must match the head of the expected stream
    always @(negedge clk) begin
        if (!rst && sif.instr_valid) begin
            if (q.size() == 0) check("spurious_valid", int'(sif.instr_valid), 0);
            else begin
                check("word", int'(sif.instr_out), q[0].w);
                check("pc", int'(sif.pc_out), q[0].pc);
                if (sif.instr_ready) begin
                    void'(q.pop_front());
                    xc.push_back(cyc);
                end
            end
        end
    end
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic load(input int a, input int d);
        load_addr = AW'(a);
        load_data = IW'(d);
        load_en = 1;
        tick();
        load_en = 0;
    endtask
    task automatic push(input int p, input int w);
        exp_t e;
        e.pc = p;
        e.w = w;
        q.push_back(e);
    endtask
    task automatic pulse_start();
        start = 1;
        tick();
        start = 0;
    endtask
    task automatic pulse_step();
        step = 1;
        tick();
        step = 0;
    endtask
    task automatic wait_idle(input string tag, input int max);
        for (int i = 0; i < max && busy; i++) tick();
        check({tag, "_idle"}, int'(busy), 0);
    endtask
    task automatic wait_valid(input string tag, input int max);
        for (int i = 0; i < max && !sif.instr_valid; i++) tick();
        check({tag, "_valid"}, int'(sif.instr_valid), 1);
    endtask
    task automatic wait_count(input string tag, input int n, input int max);
        for (int i = 0; i < max && int'(issue_count) != n; i++) tick();
        check({tag, "_count"}, int'(issue_count), n);
    endtask
    task automatic check_cleared(input string tag);
        check({tag, "_valid"}, int'(sif.instr_valid), 0);
        check({tag, "_busy"}, int'(busy), 0);
        check({tag, "_done"}, int'(done), 0);
        check({tag, "_overrun"}, int'(overrun), 0);
        check({tag, "_load_err"}, int'(load_err), 0);
        check({tag, "_count"}, int'(issue_count), 0);
        check({tag, "_pc"}, int'(sif.pc_out), 0);
        check({tag, "_instr"}, int'(sif.instr_out), 0);
    endtask
    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
    initial begin
        sif.instr_ready = 0;
        repeat (3) tick();
        rst = 0;
        check_cleared("reset");
        // basic EOF-terminated program at full ready
        load(0, 'h5102);
        load(1, 'h0203);
        load(2, 'h0000);
        sif.instr_ready = 1;
        push(0, 'h5102);
        push(1, 'h0203);
        push(2, 'h0000);
        xc.delete();
        t0 = cyc;
        pulse_start();
        wait_idle("t1", 100);
        check("t1_done", int'(done), 1);
        check("t1_count", int'(issue_count), 3);
        check("t1_overrun", int'(overrun), 0);
        check("t1_qempty", q.size(), 0);
        check("t1_xfers", xc.size(), 3);
        check("t1_latency", xc.size() > 0 ? xc[0] - t0 : -1, 2);
        check("t1_gap1", xc.size() > 1 ? xc[1] - xc[0] : -1, 8);
        check("t1_gap2", xc.size() > 2 ? xc[2] - xc[1] : -1, 8);
        // back-pressure on the second word
        sif.instr_ready = 0;
        push(0, 'h5102);
        push(1, 'h0203);
        push(2, 'h0000);
        pulse_start();
        wait_valid("t2_w0", 10);
        sif.instr_ready = 1;
        tick();
        sif.instr_ready = 0;
        wait_valid("t2_w1", 20);
        for (int i = 0; i < 5; i++) begin
            check("t2_stall_valid", int'(sif.instr_valid), 1);
            check("t2_stall_pc", int'(sif.pc_out), 1);
            check("t2_stall_count", int'(issue_count), 1);
            tick();
        end
        sif.instr_ready = 1;
        wait_idle("t2", 100);
        check("t2_count", int'(issue_count), 3);
        check("t2_done", int'(done), 1);
        // no EOF in the buffer: overrun, then looping
        load(0, 'h1111);
        load(1, 'h2222);
        load(2, 'h3333);
        load(3, 'h4444);
        for (int i = 0; i < 4; i++) push(i, 'h1111 * (i + 1));
        pulse_start();
        wait_idle("t3", 100);
        check("t3_done", int'(done), 1);
        check("t3_overrun", int'(overrun), 1);
        check("t3_count", int'(issue_count), 4);
        check("t3_qempty", q.size(), 0);
        loop_en = 1;
        for (int i = 0; i < 8; i++) push(i % 4, 'h1111 * (i % 4 + 1));
        pulse_start();
        wait_count("t3_loop", 6, 120);
        check("t3_wrap_pc", int'(sif.pc_out), 1);
        check("t3_loop_done", int'(done), 0);
        check("t3_loop_busy", int'(busy), 1);
        abort = 1;
        tick();
        abort = 0;
        check("t3_abort_busy", int'(busy), 0);
        check("t3_abort_done", int'(done), 0);
        check("t3_abort_overrun", int'(overrun), 0);
        q.delete();
        loop_en = 0;
        // single-step: one word per pulse, pulses during hold ignored
        load(0, 'h5102);
        load(1, 'h0203);
        load(2, 'h0000);
        step_mode = 1;
        push(0, 'h5102);
        push(1, 'h0203);
        push(2, 'h0000);
        pulse_start();
        wait_count("t4_first", 1, 20);
        pulse_step();
        repeat (20) tick();
        check("t4_hold_step_ignored", int'(issue_count), 1);
        for (int k = 2; k <= 3; k++) begin
            pulse_step();
            repeat (20) tick();
            check("t4_step_count", int'(issue_count), k);
        end
        check("t4_wait_done", int'(done), 0);
        check("t4_wait_busy", int'(busy), 1);
        pulse_step();
        check("t4_done", int'(done), 1);
        check("t4_busy", int'(busy), 0);
        check("t4_count", int'(issue_count), 3);
        step_mode = 0;
        // abort while a word is being offered
        sif.instr_ready = 0;
        push(0, 'h5102);
        pulse_start();
        wait_valid("t5_abort", 10);
        abort = 1;
        tick();
        abort = 0;
        check("t5_abort_valid", int'(sif.instr_valid), 0);
        check("t5_abort_busy", int'(busy), 0);
        check("t5_abort_done", int'(done), 0);
        check("t5_abort_count", int'(issue_count), 0);
        q.delete();
        // dropped load while busy, then reset during hold
        sif.instr_ready = 1;
        push(0, 'h5102);
        pulse_start();
        load(0, 'hdead);
        check("t5_load_err", int'(load_err), 1);
        wait_count("t5_hold", 1, 20);
        rst = 1;
        tick();
        rst = 0;
        check_cleared("t5_rst");
        q.delete();
        push(0, 'h5102);
        push(1, 'h0203);
        push(2, 'h0000);
        pulse_start();
        wait_idle("t5_rerun", 100);
        check("t5_rerun_count", int'(issue_count), 3);
        check("t5_rerun_qempty", q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
